// File: rtl/portrait_pkg.sv
// Shared types and constants for the portrait compositor: fade states, pixel type
// and the 16-entry portrait palette (index 0 is the colour key).
package portrait_pkg;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    typedef logic [23:0] rgb_t;

    localparam rgb_t PORTRAIT_PALETTE [16] = '{
        24'h000000, 24'hFF0000, 24'h00FF00, 24'h3060C0,
        24'hF8D8B0, 24'h7A4A2A, 24'h202020, 24'hFFFFFF,
        24'hC03030, 24'h2050A0, 24'h80C0E0, 24'hE0B040,
        24'h406030, 24'hA0A0A0, 24'h603080, 24'hF0F0A0
    };

endpackage

// File: rtl/portrait_alpha_blend.sv
// Combinational per-channel alpha blend of a foreground over a background pixel:
// out = (fg*alpha + bg*(FADE_MAX-alpha)) >> FADE_SHIFT.
module portrait_alpha_blend
    import portrait_pkg::*;
#(
    parameter int FADE_SHIFT = 3
) (
    input  rgb_t        fg,
    input  rgb_t        bg,
    input  logic [3:0]  alpha,
    output rgb_t        blended
);

    localparam logic [3:0] FADE_MAX_A = 4'(1 << FADE_SHIFT);

    // Largest sum is 255*FADE_MAX, so 12 bits never overflow.
    function automatic logic [7:0] mix(input logic [7:0] f, input logic [7:0] b, input logic [3:0] a);
        logic [11:0] fa;
        logic [11:0] ba;
        logic [11:0] sum;
        fa  = {4'h0, f} * {8'h00, a};
        ba  = {4'h0, b} * {8'h00, FADE_MAX_A - a};
        sum = fa + ba;
        return 8'(sum >> FADE_SHIFT);
    endfunction

    // Blend the three colour channels independently.
    always_comb begin
        blended = {mix(fg[23:16], bg[23:16], alpha),
                   mix(fg[15:8],  bg[15:8],  alpha),
                   mix(fg[7:0],   bg[7:0],   alpha)};
    end

endmodule

// File: rtl/portrait_compositor.sv
// Realigns the sprite ROM output with the background, applies palette, colour key
// and a frame-synchronous fade, and tells the sprite stage when to fetch.
module portrait_compositor
    import portrait_pkg::*;
#(
    parameter int         FADE_SHIFT      = 3,
    parameter int         FRAMES_PER_STEP = 4,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        show_req,
    input  logic        hide_req,
    input  logic        is_portrait,
    input  logic [3:0]  portrait_data,
    input  logic [23:0] bg_rgb,
    output logic        portrait_exist,
    output logic [23:0] pixel_rgb,
    output logic        fade_busy,
    output logic [3:0]  alpha
);

    localparam logic [3:0] FADE_MAX_A = 4'(1 << FADE_SHIFT);
    localparam logic [7:0] STEP_LAST  = 8'(FRAMES_PER_STEP - 1);

    fade_state_t state;
    logic [7:0]  frame_cnt;
    logic        flag_d;
    rgb_t        bg_d;
    rgb_t        pal_rgb;
    rgb_t        blended;
    logic        use_portrait;
    logic        step_due;

    assign pal_rgb      = PORTRAIT_PALETTE[portrait_data];
    assign use_portrait = flag_d && (portrait_data != TRANSPARENT_IDX) && (alpha != 4'd0);
    assign step_due     = (frame_cnt == STEP_LAST);

    portrait_alpha_blend #(
        .FADE_SHIFT (FADE_SHIFT)
    ) u_blend (
        .fg      (pal_rgb),
        .bg      (bg_d),
        .alpha   (alpha),
        .blended (blended)
    );

    // Two-stage pixel pipeline: align flag/background with the ROM data, then composite.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flag_d    <= 1'b0;
            bg_d      <= 24'h000000;
            pixel_rgb <= 24'h000000;
        end else begin
            flag_d    <= is_portrait;
            bg_d      <= bg_rgb;
            pixel_rgb <= use_portrait ? blended : bg_d;
        end
    end

    // Fade FSM; a request taken in a cycle consumes any coincident frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= HIDDEN;
            alpha          <= 4'd0;
            frame_cnt      <= 8'd0;
            fade_busy      <= 1'b0;
            portrait_exist <= 1'b0;
        end else begin
            case (state)
                HIDDEN: begin
                    alpha <= 4'd0;
                    if (show_req && !hide_req) begin
                        state          <= FADE_IN;
                        frame_cnt      <= 8'd0;
                        fade_busy      <= 1'b1;
                        portrait_exist <= 1'b1;
                    end
                end
                FADE_IN: begin
                    if (hide_req) begin
                        state     <= FADE_OUT;
                        frame_cnt <= 8'd0;
                    end else if (frame_start) begin
                        if (step_due) begin
                            frame_cnt <= 8'd0;
                            if (alpha >= FADE_MAX_A - 4'd1) begin
                                alpha     <= FADE_MAX_A;
                                state     <= SHOWN;
                                fade_busy <= 1'b0;
                            end else begin
                                alpha <= alpha + 4'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                SHOWN: begin
                    alpha <= FADE_MAX_A;
                    if (hide_req) begin
                        state     <= FADE_OUT;
                        frame_cnt <= 8'd0;
                        fade_busy <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (show_req && !hide_req) begin
                        state     <= FADE_IN;
                        frame_cnt <= 8'd0;
                    end else if (frame_start) begin
                        if (step_due) begin
                            frame_cnt <= 8'd0;
                            if (alpha <= 4'd1) begin
                                alpha          <= 4'd0;
                                state          <= HIDDEN;
                                fade_busy      <= 1'b0;
                                portrait_exist <= 1'b0;
                            end else begin
                                alpha <= alpha - 4'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state          <= HIDDEN;
                    alpha          <= 4'd0;
                    frame_cnt      <= 8'd0;
                    fade_busy      <= 1'b0;
                    portrait_exist <= 1'b0;
                end
            endcase
        end
    end

endmodule
